// File: rtl/apb_stream_mailbox_pkg.sv
// Shared constants and types for the APB <-> stream mailbox.
// Register offsets are PADDR[4:2]; bit positions are within the 32-bit register.
package apb_stream_mailbox_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_FULL      = 2;
  localparam int unsigned ST_RX_EMPTY     = 3;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;
  localparam int unsigned CNT_FIELD_W     = 4;

  localparam int unsigned CTRL_BLOCKING = 0;
  localparam int unsigned CTRL_RX_EV_EN = 1;
  localparam int unsigned CTRL_TX_EV_EN = 2;
  localparam int unsigned CTRL_TX_FLUSH = 3;
  localparam int unsigned CTRL_RX_FLUSH = 4;
  localparam int unsigned CTRL_STORE_W  = 3;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic {
    WAIT_IDLE,
    WAIT_STALL
  } wait_state_e;

endpackage

// File: rtl/apb_stream_mailbox_if.sv
// APB completer bus bundle used by the mailbox.
interface apb_stream_mailbox_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_stream_mailbox_fifo.sv
// Register-based synchronous FIFO with single-cycle flush; DEPTH is a power of two.
module mailbox_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        data_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign data_o = mem_q[rd_ptr_q];

  // Flush wins over any same-cycle push/pop; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/apb_stream_mailbox.sv
// APB completer moving 32-bit words between software and a TX/RX stream pair,
// with optional PREADY-stretching blocking accesses bounded by TIMEOUT.
module apb_stream_mailbox
  import apb_stream_mailbox_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  apb_stream_mailbox_if.slave         apb,
  output logic [31:0]                 tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  input  logic [31:0]                 rx_data_i,
  input  logic                        rx_valid_i,
  output logic                        rx_ready_o,
  output logic                        event_o
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wait_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CTRL_STORE_W-1:0] ctrl_q, ctrl_d;
  logic                    event_q, event_d;

  logic [2:0]    reg_sel;
  logic          access, done, blocked, pready_c, pslverr_c, unmapped;
  logic          tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0]   rx_head, status, prdata_c;
  logic          unused_paddr;

  assign unused_paddr = ^{apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};
  assign reg_sel  = apb.PADDR[4:2];
  assign access   = apb.PSEL & apb.PENABLE;
  assign unmapped = reg_sel[2];
  assign blocked  = (apb.PWRITE  & (reg_sel == REG_TXDATA) & tx_full) |
                    (!apb.PWRITE & (reg_sel == REG_RXDATA) & rx_empty);

  // Wait FSM: stretch PREADY on blocked blocking accesses, give up after TIMEOUT.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pready_c  = 1'b1;
    pslverr_c = 1'b0;
    if (!apb.PSEL) begin
      state_d = WAIT_IDLE;
      wcnt_d  = '0;
    end else if (access) begin
      if (unmapped) begin
        pslverr_c = 1'b1;
      end else if (blocked) begin
        if (!ctrl_q[CTRL_BLOCKING]) begin
          pslverr_c = 1'b1;
        end else if (state_q == WAIT_STALL && wcnt_q >= WAIT_CNT_W'(TIMEOUT)) begin
          pslverr_c = 1'b1;
          state_d   = WAIT_IDLE;
          wcnt_d    = '0;
        end else begin
          pready_c = 1'b0;
          state_d  = WAIT_STALL;
          if (state_q == WAIT_IDLE) wcnt_d = WAIT_CNT_W'(1);
          else if (wcnt_q != '1)    wcnt_d = wcnt_q + WAIT_CNT_W'(1);
        end
      end else begin
        state_d = WAIT_IDLE;
        wcnt_d  = '0;
      end
    end
  end

  assign done     = access & pready_c & ~pslverr_c;
  assign tx_push  = done & apb.PWRITE  & (reg_sel == REG_TXDATA);
  assign rx_pop   = done & !apb.PWRITE & (reg_sel == REG_RXDATA);
  assign tx_flush = done & apb.PWRITE  & (reg_sel == REG_CTRL) & apb.PWDATA[CTRL_TX_FLUSH];
  assign rx_flush = done & apb.PWRITE  & (reg_sel == REG_CTRL) & apb.PWDATA[CTRL_RX_FLUSH];
  assign tx_pop   = tx_valid_o & tx_ready_i;
  assign rx_push  = rx_valid_i & rx_ready_o;

  // CTRL storage, event level and read mux.
  always_comb begin
    ctrl_d = ctrl_q;
    if (done && apb.PWRITE && reg_sel == REG_CTRL) ctrl_d = apb.PWDATA[CTRL_STORE_W-1:0];
    event_d = (ctrl_q[CTRL_RX_EV_EN] & ~rx_empty) | (ctrl_q[CTRL_TX_EV_EN] & tx_empty);

    status                                     = '0;
    status[ST_TX_FULL]                         = tx_full;
    status[ST_TX_EMPTY]                        = tx_empty;
    status[ST_RX_FULL]                         = rx_full;
    status[ST_RX_EMPTY]                        = rx_empty;
    status[ST_TX_COUNT_LSB +: CNT_FIELD_W]     = CNT_FIELD_W'(tx_count);
    status[ST_RX_COUNT_LSB +: CNT_FIELD_W]     = CNT_FIELD_W'(rx_count);

    prdata_c = '0;
    if (access && !apb.PWRITE) begin
      case (reg_sel)
        REG_RXDATA: prdata_c = rx_head;
        REG_STATUS: prdata_c = status;
        REG_CTRL:   prdata_c = 32'(ctrl_q);
        default:    prdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= WAIT_IDLE;
      wcnt_q  <= '0;
      ctrl_q  <= '0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ctrl_q  <= ctrl_d;
      event_q <= event_d;
    end
  end

  assign apb.PRDATA  = prdata_c;
  assign apb.PREADY  = pready_c;
  assign apb.PSLVERR = pslverr_c;
  assign tx_valid_o  = ~tx_empty;
  assign rx_ready_o  = ~rx_full;
  assign event_o     = event_q;

  mailbox_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .data_i(apb.PWDATA), .data_o(tx_data_o), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  mailbox_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(HCLK), .rst_n(HRESETn), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .data_i(rx_data_i), .data_o(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );
endmodule

// File: tb/tb_apb_stream_mailbox.sv
// Directed bench for apb_stream_mailbox: APB register access, streams, blocking and events.
module tb_apb_stream_mailbox;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        event_o;

  int checks   = 0;
  int failures = 0;

  apb_stream_mailbox_if #(.APB_ADDR_WIDTH(12)) apb ();

  apb_stream_mailbox #(.APB_ADDR_WIDTH(12), .DEPTH(8), .TIMEOUT(255)) dut (
    .HCLK(clk), .HRESETn(rst_n), .apb(apb.slave),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .event_o(event_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; waits counts access-phase cycles sampled with PREADY=0.
  task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(negedge clk);
    apb.PADDR = addr; apb.PWRITE = wr; apb.PWDATA = wdata;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(negedge clk);
    apb.PENABLE = 1'b1;
    #1;
    waits = 0;
    while (!apb.PREADY && waits < 400) begin
      @(negedge clk); #1;
      waits++;
    end
    rdata = apb.PRDATA;
    err   = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;

  initial begin
    rst_n = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0; apb.PWRITE = 1'b0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pready",   32'(apb.PREADY),  32'd1);
    check("rst_pslverr",  32'(apb.PSLVERR), 32'd0);
    check("rst_prdata",   apb.PRDATA,       32'd0);
    check("rst_tx_valid", 32'(tx_valid_o),  32'd0);
    check("rst_tx_data",  tx_data_o,        32'd0);
    check("rst_rx_ready", 32'(rx_ready_o),  32'd1);
    check("rst_event",    32'(event_o),     32'd0);
    rst_n = 1'b1;

    apb_xfer(12'h008, 1'b0, 32'h0, rd, err, waits);
    check("status_reset", rd, 32'h0000_000A);
    apb_xfer(12'h00C, 1'b0, 32'h0, rd, err, waits);
    check("ctrl_reset", rd, 32'h0);
    apb_xfer(12'h004, 1'b0, 32'h0, rd, err, waits);
    check("rx_empty_nonblock_err", 32'(err), 32'd1);

    // Fill TX while the consumer is stalled.
    for (int i = 0; i < 8; i++) begin
      apb_xfer(12'h000, 1'b1, 32'h11 + 32'(i), rd, err, waits);
      check($sformatf("tx_write_%0d_err", i), 32'(err), 32'd0);
    end
    apb_xfer(12'h008, 1'b0, 32'h0, rd, err, waits);
    check("status_tx_full", rd, 32'h0000_0809);
    apb_xfer(12'h000, 1'b1, 32'h99, rd, err, waits);
    check("tx_overflow_err", 32'(err), 32'd1);
    check("tx_overflow_waits", 32'(waits), 32'd0);
    apb_xfer(12'h008, 1'b0, 32'h0, rd, err, waits);
    check("status_after_overflow", rd, 32'h0000_0809);

    // Drain TX: one word per cycle, in order.
    @(negedge clk);
    tx_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_valid_%0d", i), 32'(tx_valid_o), 32'd1);
      check($sformatf("tx_data_%0d", i),  tx_data_o,       32'h11 + 32'(i));
      @(negedge clk); #1;
    end
    check("tx_valid_drained", 32'(tx_valid_o), 32'd0);
    tx_ready_i = 1'b0;

    // Blocking RX read released by an inbound word during wait cycle 10.
    apb_xfer(12'h00C, 1'b1, 32'h1, rd, err, waits);
    fork
      apb_xfer(12'h004, 1'b0, 32'h0, rd, err, waits);
      begin
        repeat (2) @(negedge clk);
        repeat (9) @(negedge clk);
        rx_valid_i = 1'b1; rx_data_i = 32'h0000_CAFE;
        @(negedge clk);
        rx_valid_i = 1'b0; rx_data_i = '0;
      end
    join
    check("block_rx_waits", 32'(waits), 32'd10);
    check("block_rx_data",  rd,         32'h0000_CAFE);
    check("block_rx_err",   32'(err),   32'd0);

    // Blocking RX read with no input times out after exactly TIMEOUT wait cycles.
    apb_xfer(12'h004, 1'b0, 32'h0, rd, err, waits);
    check("timeout_waits", 32'(waits), 32'd255);
    check("timeout_err",   32'(err),   32'd1);
    apb_xfer(12'h008, 1'b0, 32'h0, rd, err, waits);
    check("status_after_timeout", rd, 32'h0000_000A);

    // RX event, then flush clears it one cycle after the write.
    apb_xfer(12'h00C, 1'b1, 32'h2, rd, err, waits);
    @(negedge clk);
    rx_valid_i = 1'b1; rx_data_i = 32'h55;
    @(negedge clk);
    rx_valid_i = 1'b0; rx_data_i = '0;
    #1;
    check("event_lag", 32'(event_o), 32'd0);
    @(negedge clk); #1;
    check("event_rx", 32'(event_o), 32'd1);
    apb_xfer(12'h00C, 1'b1, 32'h12, rd, err, waits);
    check("event_at_flush_edge", 32'(event_o), 32'd1);
    @(posedge clk); #1;
    check("event_after_flush", 32'(event_o), 32'd0);
    apb_xfer(12'h008, 1'b0, 32'h0, rd, err, waits);
    check("status_after_flush", rd, 32'h0000_000A);
    apb_xfer(12'h00C, 1'b0, 32'h0, rd, err, waits);
    check("ctrl_flush_selfclear", rd, 32'h0000_0002);

    apb_xfer(12'h014, 1'b0, 32'h0, rd, err, waits);
    check("unmapped_err",   32'(err),   32'd1);
    check("unmapped_waits", 32'(waits), 32'd0);
    check("unmapped_rdata", rd,         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
